hex_frame_tx: RTL and testbench
===============================

Name: hex_frame_tx

Overview:
- Parametrised successor to the single-word hex UART transmitter.
- Snapshots NCH channels of WIDTH-bit data on a valid/ready handshake and emits them as one ASCII line:
  - uppercase hex, MSB nibble first per channel;
  - channels separated by SEP;
  - line terminated by CR and, optionally, LF.
- Output is a byte stream with valid/ready handshake, feeding the team's uart_tx byte port (or a FIFO in front of it). This replaces the free-running, TXIF-clocked nibble loop.

Parameters:
- WIDTH, 32, bits per channel; must be a multiple of 4 and at least 4.
- NCH, 4, number of channels per frame; at least 1.
- SEP, 8'h2C, separator byte inserted between channels (ASCII ',').
- TERM_LF, 1, 1 = terminate with CR LF (0x0D 0x0A); 0 = CR only.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; channel 0 is sent first.
- in_valid  input  1  frame request.
- in_ready  output  1  high only in IDLE; a frame is accepted when in_valid && in_ready.
- tx_data  output  8  current ASCII byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready.
- busy  output  1  high from frame accept until the final terminator byte is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, tx_valid=0, tx_data=8'h00, busy=0. All counters and the snapshot register are cleared.
- Reset asserted mid-frame aborts the frame immediately. No partial output resumes after reset.
- States: IDLE, NIB, SEP, CR, LF. CKS_STAR, CKS_HI and CKS_LO exist only with CHECKSUM_EN.
- IDLE:
  - On accept, latch in_data into the snapshot; channel index = 0; nibble index = WIDTH/4-1; go to NIB.
  - Later changes on in_data are ignored until the next accept.
- Latency: accept at edge t puts the first character on tx_data with tx_valid=1 after edge t (valid in cycle t+1).
- Character encoding:
  - nibble 0-9 -> 0x30+n;
  - nibble A-F -> 0x41+(n-10).
- Byte handshake:
  - tx_data and tx_valid are registered and held stable while tx_valid && !tx_ready.
  - On a transfer, the next byte is presented in the following cycle with tx_valid kept high, so throughput is one byte per cycle under continuous tx_ready.
  - tx_valid is never dropped mid-frame.
- NIB:
  - On a transfer with nibble index > 0, decrement the nibble index.
  - On a transfer with nibble index 0:
    - if channel < NCH-1: go to SEP;
    - otherwise: go to CR (or CKS_STAR when CHECKSUM_EN).
- SEP: emits SEP. On transfer, increment the channel, reload the nibble index, return to NIB.
- CR: emits 0x0D. On transfer, go to LF if TERM_LF, else go to IDLE.
- LF: emits 0x0A. On transfer, go to IDLE.
- Frame end: on the final transfer, tx_valid=0, busy=0 and in_ready=1 in the next cycle.
  - There is no back-to-back overlap; at least one idle cycle separates frames.
- Frame length in bytes = NCH*WIDTH/4 + (NCH-1) + 1 + TERM_LF (+3 with CHECKSUM_EN).
- in_valid while busy is ignored (in_ready=0) and is not queued.
- A simultaneous in_valid and final-byte transfer is not accepted in that cycle.

Optional Feature:
- Macro: HEX_FRAME_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every byte transferred in NIB and SEP. It clears on accept.
  - After the last nibble, the block emits '*' (0x2A), then the checksum as two uppercase hex characters (high nibble first), then the terminator.
- Undefined: no checksum logic or states are present, and the frame goes directly from the last nibble to CR.

Test Plan:
- WIDTH=32, NCH=2, ch0=32'h0123ABCD, ch1=0, tx_ready tied 1 -> bytes "0123ABCD,00000000" 0x0D 0x0A. That is 19 consecutive cycles with tx_valid=1, then busy=0 and in_ready=1.
- WIDTH=4, NCH=3, in_data=12'hF90, TERM_LF=0 -> "0,9,F" 0x0D (6 bytes). in_data changed to 0 one cycle after accept has no effect on the output.
- Backpressure: same frame as the first case, tx_ready alternating 1/0 -> identical byte sequence; tx_data stable during every tx_ready=0 cycle; no byte lost or duplicated.
- in_valid held high throughout -> exactly one frame per accept, with one idle cycle (in_ready=1) between frames. Pulses while busy=1 produce no extra frame.
- rst_n pulsed low after the 3rd transferred byte -> outputs immediately return to reset values. A new request then starts from the channel 0 MSB nibble.
- HEX_FRAME_CHECKSUM_EN, WIDTH=8, NCH=1, data 8'hA5 -> "A5*74" 0x0D 0x0A (0x41^0x35=0x74).

Source files
------------

// File: rtl/hex_frame_tx_if.sv
// rtl/hex_frame_tx_if.sv - frame request and ASCII byte stream handshake bundle for hex_frame_tx
interface hex_frame_tx_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
);
    logic [NCH*WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;

    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid, busy
    );

    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/hex_frame_tx.sv
// rtl/hex_frame_tx.sv - NCH x WIDTH snapshot to one ASCII hex line (optional HEX_FRAME_CHECKSUM_EN adds "*XX")
module hex_frame_tx #(
    parameter int         WIDTH   = 32,
    parameter int         NCH     = 4,
    parameter logic [7:0] SEP     = 8'h2C,
    parameter int         TERM_LF = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    hex_frame_tx_if.slave bus
);
    localparam int NNIB  = WIDTH / 4;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NIB_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NIB,
        S_SEP,
        S_CR,
        S_LF
`ifdef HEX_FRAME_CHECKSUM_EN
        ,
        S_CKS_STAR,
        S_CKS_HI,
        S_CKS_LO
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [NCH*WIDTH-1:0] snap_q, snap_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [NIB_W-1:0]     nib_q, nib_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 xfer;
    logic [3:0]           nib_sel;
    int                   flat_idx;
`ifdef HEX_FRAME_CHECKSUM_EN
    logic [7:0]           cks_q, cks_d;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign xfer         = tx_valid_q && bus.tx_ready;
    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

    // State, snapshot, indices and the registered output byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            snap_q     <= '0;
            ch_q       <= '0;
            nib_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
`ifdef HEX_FRAME_CHECKSUM_EN
            cks_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            ch_q       <= ch_d;
            nib_q      <= nib_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
`ifdef HEX_FRAME_CHECKSUM_EN
            cks_q      <= cks_d;
`endif
        end
    end

    // Next state: advance one character per accepted byte
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        ch_d    = ch_q;
        nib_d   = nib_q;
`ifdef HEX_FRAME_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    snap_d  = bus.in_data;
                    ch_d    = '0;
                    nib_d   = NIB_W'(NNIB - 1);
                    state_d = S_NIB;
`ifdef HEX_FRAME_CHECKSUM_EN
                    cks_d   = 8'h00;
`endif
                end
            end
            S_NIB: begin
                if (xfer) begin
`ifdef HEX_FRAME_CHECKSUM_EN
                    cks_d = cks_q ^ tx_data_q;
`endif
                    if (nib_q != '0) begin
                        nib_d = nib_q - NIB_W'(1);
                    end else if (int'(ch_q) < NCH - 1) begin
                        state_d = S_SEP;
                    end else begin
`ifdef HEX_FRAME_CHECKSUM_EN
                        state_d = S_CKS_STAR;
`else
                        state_d = S_CR;
`endif
                    end
                end
            end
            S_SEP: begin
                if (xfer) begin
`ifdef HEX_FRAME_CHECKSUM_EN
                    cks_d = cks_q ^ tx_data_q;
`endif
                    ch_d    = ch_q + CH_W'(1);
                    nib_d   = NIB_W'(NNIB - 1);
                    state_d = S_NIB;
                end
            end
`ifdef HEX_FRAME_CHECKSUM_EN
            S_CKS_STAR: if (xfer) state_d = S_CKS_HI;
            S_CKS_HI:   if (xfer) state_d = S_CKS_LO;
            S_CKS_LO:   if (xfer) state_d = S_CR;
`endif
            S_CR: if (xfer) state_d = (TERM_LF != 0) ? S_LF : S_IDLE;
            S_LF: if (xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output: encode the byte that belongs to the upcoming state, so it is registered
    always_comb begin
        flat_idx = int'(ch_d) * NNIB + int'(nib_d);
        nib_sel  = 4'h0;
        for (int k = 0; k < NCH * NNIB; k++) begin
            if (k == flat_idx) nib_sel = snap_d[k*4 +: 4];
        end
        tx_valid_d = (state_d != S_IDLE);
        case (state_d)
            S_NIB:      tx_data_d = hex_char(nib_sel);
            S_SEP:      tx_data_d = SEP;
            S_CR:       tx_data_d = 8'h0D;
            S_LF:       tx_data_d = 8'h0A;
`ifdef HEX_FRAME_CHECKSUM_EN
            S_CKS_STAR: tx_data_d = 8'h2A;
            S_CKS_HI:   tx_data_d = hex_char(cks_d[7:4]);
            S_CKS_LO:   tx_data_d = hex_char(cks_d[3:0]);
`endif
            default:    tx_data_d = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_hex_frame_tx.sv
// tb/tb_hex_frame_tx.sv - self-checking bench for hex_frame_tx
module tb_hex_frame_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    hex_frame_tx_if #(.WIDTH(32), .NCH(2)) ifa ();
    hex_frame_tx_if #(.WIDTH(4),  .NCH(3)) ifb ();

    hex_frame_tx #(.WIDTH(32), .NCH(2), .SEP(8'h2C), .TERM_LF(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    hex_frame_tx #(.WIDTH(4), .NCH(3), .SEP(8'h2C), .TERM_LF(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic o_valid(input int sel);
        return (sel != 0) ? ifb.tx_valid : ifa.tx_valid;
    endfunction
    function automatic logic [7:0] o_data(input int sel);
        return (sel != 0) ? ifb.tx_data : ifa.tx_data;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel != 0) ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic o_inrdy(input int sel);
        return (sel != 0) ? ifb.in_ready : ifa.in_ready;
    endfunction

    // Reference: the ASCII line the frame should produce, built from the data word
    task automatic model_frame(input logic [63:0] d, input int w, input int nch, input int lf);
        string      hx = "0123456789ABCDEF";
        logic [7:0] x;
        int         nb;
        exp_q.delete();
        x = 8'h00;
        for (int k = 0; k < nch; k++) begin
            if (k > 0) exp_q.push_back(8'h2C);
            for (int i = w / 4 - 1; i >= 0; i--) begin
                nb = int'((d >> (k * w + 4 * i)) & 64'hF);
                exp_q.push_back(hx.getc(nb));
            end
        end
`ifdef HEX_FRAME_CHECKSUM_EN
        foreach (exp_q[j]) x = x ^ exp_q[j];
        exp_q.push_back(8'h2A);
        exp_q.push_back(hx.getc(int'(x[7:4])));
        exp_q.push_back(hx.getc(int'(x[3:0])));
`endif
        exp_q.push_back(8'h0D);
        if (lf != 0) exp_q.push_back(8'h0A);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge
    task automatic start(input int sel, input logic [63:0] d, input logic hold, input logic [63:0] d_after);
        if (sel != 0) begin ifb.in_data = d[11:0]; ifb.in_valid = 1'b1; end
        else begin ifa.in_data = d; ifa.in_valid = 1'b1; end
        chk("start_in_ready", o_inrdy(sel), 1);
        @(negedge clk);
        chk("first_byte_valid", o_valid(sel), 1);
        chk("busy_after_accept", o_busy(sel), 1);
        chk("in_ready_busy", o_inrdy(sel), 0);
        if (sel != 0) begin ifb.in_valid = hold; ifb.in_data = d_after[11:0]; end
        else begin ifa.in_valid = hold; ifa.in_data = d_after; end
    endtask

    // mode 0: ready always, 1: alternating, 2: random
    task automatic collect(input int sel, input int n, input int mode, output int vcyc);
        logic       stall, r;
        logic [7:0] pd;
        int         budget;
        got_q.delete();
        stall = 1'b0; pd = 8'h00; vcyc = 0; budget = 0;
        while (got_q.size() < n && budget < 400) begin
            if (stall) chk("stall_data_stable", o_data(sel), pd);
            chk("valid_mid_frame", o_valid(sel), 1);
            if (o_valid(sel)) vcyc++;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ((budget % 2) == 0) : 1'($urandom_range(0, 1));
            ifa.tx_ready = r;
            ifb.tx_ready = r;
            if (o_valid(sel) && r) got_q.push_back(o_data(sel));
            stall = o_valid(sel) && !r;
            pd = o_data(sel);
            budget++;
            @(negedge clk);
        end
        chk("frame_in_budget", (budget < 400), 1);
        chk("end_tx_valid", o_valid(sel), 0);
        chk("end_busy", o_busy(sel), 0);
        chk("end_in_ready", o_inrdy(sel), 1);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        int         vc;
        logic [63:0] d;
        rst_n = 1'b0;
        ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.tx_ready = 1'b0;
        ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.tx_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_tx_valid", ifa.tx_valid, 0);
        chk("rst_tx_data", ifa.tx_data, 8'h00);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_b_in_ready", ifb.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: "0123ABCD,00000000" CR LF at full rate
        d = {32'h0000_0000, 32'h0123_ABCD};
        model_frame(d, 32, 2, 1);
        start(0, d, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        collect(0, exp_q.size(), 0, vc);
        chk("t1_valid_cycles", vc, exp_q.size());
        compare("t1");

        // Directed: narrow channels, CR only, input changed after accept
        model_frame(64'hF90, 4, 3, 0);
        start(1, 64'hF90, 1'b0, 64'h0);
        collect(1, exp_q.size(), 0, vc);
        compare("t2");

        // Backpressure: alternating ready on the first frame
        model_frame(d, 32, 2, 1);
        start(0, d, 1'b0, 64'h0);
        collect(0, exp_q.size(), 1, vc);
        compare("t3");

        // Random data and random ready on both instances
        for (int f = 0; f < 6; f++) begin
            d = {$urandom, $urandom};
            model_frame(d, 32, 2, 1);
            start(0, d, 1'b0, {$urandom, $urandom});
            collect(0, exp_q.size(), 2, vc);
            compare($sformatf("rnd_a%0d", f));
        end
        for (int f = 0; f < 4; f++) begin
            d = 64'($urandom_range(0, 4095));
            model_frame(d, 4, 3, 0);
            start(1, d, 1'b0, 64'($urandom_range(0, 4095)));
            collect(1, exp_q.size(), 2, vc);
            compare($sformatf("rnd_b%0d", f));
        end

        // in_valid held high: one frame per accept, idle cycle between frames
        d = {$urandom, $urandom};
        model_frame(d, 32, 2, 1);
        start(0, d, 1'b1, d);
        collect(0, exp_q.size(), 2, vc);
        compare("hold_f1");
        @(negedge clk);
        chk("hold_reaccept_busy", ifa.busy, 1);
        collect(0, exp_q.size(), 0, vc);
        compare("hold_f2");
        ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("hold_no_extra_busy", ifa.busy, 0);
        chk("hold_no_extra_valid", ifa.tx_valid, 0);

        // Reset after the 3rd byte aborts the frame
        d = {32'h1357_9BDF, 32'h2468_ACE0};
        start(0, d, 1'b0, 64'h0);
        ifa.tx_ready = 1'b1; ifb.tx_ready = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", ifa.tx_valid, 0);
        chk("abort_tx_data", ifa.tx_data, 8'h00);
        chk("abort_busy", ifa.busy, 0);
        chk("abort_in_ready", ifa.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_idle", ifa.tx_valid, 0);
        model_frame(d, 32, 2, 1);
        start(0, d, 1'b0, 64'h0);
        collect(0, exp_q.size(), 0, vc);
        compare("post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
